fractal_sync_initiator: RTL and testbench

//  Core-side endpoint of the fractal synchronization network. It accepts one barrier request
//  (level, id) from a core and drives a single-cycle sync request into the fsync pipeline.
//  It then waits for the matching wake response and hands the result (ok/error/timeout) back
//  to the core. One barrier is outstanding at a time; it sits between core and pipeline.

---
 rtl/fractal_sync_initiator.sv | 164 ++++++++++++++++
 tb/tb_fractal_sync_initiator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_initiator.sv
// Core-side endpoint of the fractal sync network: issues one barrier sync per core
// request, waits for the matching wake (or a timeout) and returns the result to the core.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a core request
// ISSUE  | sync pulse on the fsync request port, wake may already match
// WAIT   | waiting for the matching wake, timeout timer running
// RESP   | result presented to the core until accepted
module fractal_sync_initiator #(
  parameter int unsigned LVL_W          = 4,
  parameter int unsigned ID_W           = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             core_req_valid_i,
  output logic             core_req_ready_o,
  input  logic [LVL_W-1:0] core_req_lvl_i,
  input  logic [ID_W-1:0]  core_req_id_i,
  output logic             core_rsp_valid_o,
  input  logic             core_rsp_ready_i,
  output logic             core_rsp_error_o,
  output logic             core_rsp_timeout_o,
  output logic             fsync_req_sync_o,
  output logic [LVL_W-1:0] fsync_req_lvl_o,
  output logic [ID_W-1:0]  fsync_req_id_o,
  input  logic             fsync_rsp_wake_i,
  input  logic [LVL_W-1:0] fsync_rsp_lvl_i,
  input  logic [ID_W-1:0]  fsync_rsp_id_i,
  input  logic             fsync_rsp_error_i,
  output logic             stray_o,
  output logic             busy_o
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             sync_q, sync_d;
  logic [LVL_W-1:0] req_lvl_q, req_lvl_d;
  logic [ID_W-1:0]  req_id_q, req_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_error_q, rsp_error_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             stray_q, stray_d;

  logic match;
  logic timeout_hit;
  logic pending;

  assign match       = fsync_rsp_wake_i && (fsync_rsp_lvl_i == lvl_q) && (fsync_rsp_id_i == id_q);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);
  assign pending     = (state_q == S_ISSUE) || (state_q == S_WAIT);

  always_comb begin
    state_d       = state_q;
    lvl_d         = lvl_q;
    id_d          = id_q;
    timer_d       = '0;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    stray_d       = fsync_rsp_wake_i && !(pending && match);

    case (state_q)
      S_IDLE: begin
        if (core_req_valid_i) begin
          lvl_d = core_req_lvl_i;
          id_d  = core_req_id_i;
          if (core_req_lvl_i != '0) begin
            state_d = S_ISSUE;
          end else begin
            state_d       = S_RESP;
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        if (match) begin
          state_d       = S_RESP;
          rsp_error_d   = fsync_rsp_error_i;
          rsp_timeout_d = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // a wake arriving on the timeout cycle still counts as a normal completion
        if (match) begin
          state_d       = S_RESP;
          rsp_error_d   = fsync_rsp_error_i;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d       = S_RESP;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + TMR_W'(1);
        end else begin
          timer_d = timer_q;
        end
      end
      S_RESP: begin
        if (core_rsp_ready_i) begin
          state_d       = S_IDLE;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    sync_d      = (state_d == S_ISSUE);
    req_lvl_d   = (state_d == S_ISSUE) ? lvl_d : '0;
    req_id_d    = (state_d == S_ISSUE) ? id_d : '0;
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      lvl_q         <= '0;
      id_q          <= '0;
      timer_q       <= '0;
      sync_q        <= 1'b0;
      req_lvl_q     <= '0;
      req_id_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      lvl_q         <= lvl_d;
      id_q          <= id_d;
      timer_q       <= timer_d;
      sync_q        <= sync_d;
      req_lvl_q     <= req_lvl_d;
      req_id_q      <= req_id_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      stray_q       <= stray_d;
    end
  end

  assign core_req_ready_o   = (state_q == S_IDLE);
  assign busy_o             = (state_q != S_IDLE);
  assign core_rsp_valid_o   = rsp_valid_q;
  assign core_rsp_error_o   = rsp_error_q;
  assign core_rsp_timeout_o = rsp_timeout_q;
  assign fsync_req_sync_o   = sync_q;
  assign fsync_req_lvl_o    = req_lvl_q;
  assign fsync_req_id_o     = req_id_q;
  assign stray_o            = stray_q;

endmodule

// File: tb/tb_fractal_sync_initiator.sv
// Directed bench for fractal_sync_initiator with an 8-cycle timeout; expected values
// are hand-derived cycle by cycle relative to the sync pulse.
module tb_fractal_sync_initiator;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       core_req_valid_i;
  logic       core_req_ready_o;
  logic [3:0] core_req_lvl_i;
  logic [7:0] core_req_id_i;
  logic       core_rsp_valid_o;
  logic       core_rsp_ready_i;
  logic       core_rsp_error_o;
  logic       core_rsp_timeout_o;
  logic       fsync_req_sync_o;
  logic [3:0] fsync_req_lvl_o;
  logic [7:0] fsync_req_id_o;
  logic       fsync_rsp_wake_i;
  logic [3:0] fsync_rsp_lvl_i;
  logic [7:0] fsync_rsp_id_i;
  logic       fsync_rsp_error_i;
  logic       stray_o;
  logic       busy_o;

  int checks = 0;
  int failures = 0;

  fractal_sync_initiator #(.LVL_W(4), .ID_W(8), .TIMEOUT_CYCLES(8)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .core_req_valid_i   (core_req_valid_i),
    .core_req_ready_o   (core_req_ready_o),
    .core_req_lvl_i     (core_req_lvl_i),
    .core_req_id_i      (core_req_id_i),
    .core_rsp_valid_o   (core_rsp_valid_o),
    .core_rsp_ready_i   (core_rsp_ready_i),
    .core_rsp_error_o   (core_rsp_error_o),
    .core_rsp_timeout_o (core_rsp_timeout_o),
    .fsync_req_sync_o   (fsync_req_sync_o),
    .fsync_req_lvl_o    (fsync_req_lvl_o),
    .fsync_req_id_o     (fsync_req_id_o),
    .fsync_rsp_wake_i   (fsync_rsp_wake_i),
    .fsync_rsp_lvl_i    (fsync_rsp_lvl_i),
    .fsync_rsp_id_i     (fsync_rsp_id_i),
    .fsync_rsp_error_i  (fsync_rsp_error_i),
    .stray_o            (stray_o),
    .busy_o             (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // valid, ready, error, timeout, sync, stray, busy in one call
  task automatic chk_all(input string tag, input logic rv, input logic qr, input logic er,
                         input logic to, input logic sy, input logic st, input logic bz);
    chk({tag, ".rsp_valid"}, 32'(core_rsp_valid_o), 32'(rv));
    chk({tag, ".req_ready"}, 32'(core_req_ready_o), 32'(qr));
    chk({tag, ".rsp_error"}, 32'(core_rsp_error_o), 32'(er));
    chk({tag, ".rsp_timeout"}, 32'(core_rsp_timeout_o), 32'(to));
    chk({tag, ".sync"}, 32'(fsync_req_sync_o), 32'(sy));
    chk({tag, ".stray"}, 32'(stray_o), 32'(st));
    chk({tag, ".busy"}, 32'(busy_o), 32'(bz));
  endtask

  task automatic set_req(input logic v, input logic [3:0] l, input logic [7:0] i);
    core_req_valid_i = v;
    core_req_lvl_i   = l;
    core_req_id_i    = i;
  endtask

  task automatic set_wake(input logic w, input logic [3:0] l, input logic [7:0] i, input logic e);
    fsync_rsp_wake_i  = w;
    fsync_rsp_lvl_i   = l;
    fsync_rsp_id_i    = i;
    fsync_rsp_error_i = e;
  endtask

  initial begin
    rst_i = 1'b1;
    core_rsp_ready_i = 1'b0;
    set_req(1'b0, 4'd0, 8'h00);
    set_wake(1'b0, 4'd0, 8'h00, 1'b0);
    tick();
    tick();
    chk_all("reset", 0, 1, 0, 0, 0, 0, 0);
    chk("reset.req_lvl", 32'(fsync_req_lvl_o), 32'd0);
    chk("reset.req_id", 32'(fsync_req_id_o), 32'd0);
    rst_i = 1'b0;

    // 1: wake 3 cycles after the pulse, response 4 cycles after it
    set_req(1'b1, 4'd2, 8'h11);
    tick();
    set_req(1'b0, 4'd0, 8'h00);
    chk_all("t1.pulse", 0, 0, 0, 0, 1, 0, 1);
    chk("t1.pulse_lvl", 32'(fsync_req_lvl_o), 32'd2);
    chk("t1.pulse_id", 32'(fsync_req_id_o), 32'h11);
    tick();
    chk_all("t1.p1", 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("t1.p2", 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("t1.p3", 0, 0, 0, 0, 0, 0, 1);
    set_wake(1'b1, 4'd2, 8'h11, 1'b0);
    tick();
    set_wake(1'b0, 4'd0, 8'h00, 1'b0);
    chk_all("t1.rsp", 1, 0, 0, 0, 0, 0, 1);
    core_rsp_ready_i = 1'b1;
    tick();
    core_rsp_ready_i = 1'b0;
    chk_all("t1.done", 0, 1, 0, 0, 0, 0, 0);

    // 2: timeout after 8 WAIT cycles, late wake is a stray
    set_req(1'b1, 4'd3, 8'h22);
    tick();
    set_req(1'b0, 4'd0, 8'h00);
    chk_all("t2.pulse", 0, 0, 0, 0, 1, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t2.wait_valid", 32'(core_rsp_valid_o), 32'd0);
    end
    tick();
    chk_all("t2.timeout", 1, 0, 1, 1, 0, 0, 1);
    core_rsp_ready_i = 1'b1;
    tick();
    core_rsp_ready_i = 1'b0;
    chk_all("t2.idle", 0, 1, 0, 0, 0, 0, 0);
    set_wake(1'b1, 4'd3, 8'h22, 1'b0);
    tick();
    set_wake(1'b0, 4'd0, 8'h00, 1'b0);
    chk_all("t2.late_stray", 0, 1, 0, 0, 0, 1, 0);
    tick();
    chk_all("t2.after", 0, 1, 0, 0, 0, 0, 0);

    // 3: wrong-id wake in WAIT, then the right one with error set
    set_req(1'b1, 4'd2, 8'h11);
    tick();
    set_req(1'b0, 4'd0, 8'h00);
    tick();
    set_wake(1'b1, 4'd2, 8'h12, 1'b0);
    tick();
    set_wake(1'b0, 4'd0, 8'h00, 1'b0);
    chk_all("t3.stray", 0, 0, 0, 0, 0, 1, 1);
    tick();
    chk_all("t3.stray_end", 0, 0, 0, 0, 0, 0, 1);
    set_wake(1'b1, 4'd2, 8'h11, 1'b1);
    tick();
    set_wake(1'b0, 4'd0, 8'h00, 1'b0);
    chk_all("t3.rsp", 1, 0, 1, 0, 0, 0, 1);
    core_rsp_ready_i = 1'b1;
    tick();
    core_rsp_ready_i = 1'b0;
    chk_all("t3.done", 0, 1, 0, 0, 0, 0, 0);

    // 4: level 0 is rejected without a sync
    set_req(1'b1, 4'd0, 8'h44);
    tick();
    set_req(1'b0, 4'd0, 8'h00);
    chk_all("t4.rsp", 1, 0, 1, 0, 0, 0, 1);
    core_rsp_ready_i = 1'b1;
    tick();
    core_rsp_ready_i = 1'b0;
    chk_all("t4.done", 0, 1, 0, 0, 0, 0, 0);

    // 5: core holds off the response; queued request accepted right after handshake
    set_req(1'b1, 4'd1, 8'h55);
    tick();
    set_req(1'b1, 4'd4, 8'h66);
    chk_all("t5.pulse", 0, 0, 0, 0, 1, 0, 1);
    set_wake(1'b1, 4'd1, 8'h55, 1'b0);
    tick();
    set_wake(1'b0, 4'd0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk_all("t5.hold", 1, 0, 0, 0, 0, 0, 1);
      tick();
    end
    chk_all("t5.hs", 1, 0, 0, 0, 0, 0, 1);
    core_rsp_ready_i = 1'b1;
    tick();
    core_rsp_ready_i = 1'b0;
    chk_all("t5.idle", 0, 1, 0, 0, 0, 0, 0);
    tick();
    set_req(1'b0, 4'd0, 8'h00);
    chk_all("t5.pulse2", 0, 0, 0, 0, 1, 0, 1);
    chk("t5.pulse2_lvl", 32'(fsync_req_lvl_o), 32'd4);
    chk("t5.pulse2_id", 32'(fsync_req_id_o), 32'h66);
    set_wake(1'b1, 4'd4, 8'h66, 1'b0);
    tick();
    set_wake(1'b0, 4'd0, 8'h00, 1'b0);
    chk_all("t5.rsp2", 1, 0, 0, 0, 0, 0, 1);
    core_rsp_ready_i = 1'b1;
    tick();
    core_rsp_ready_i = 1'b0;

    // 6: reset in WAIT aborts; old wake becomes a stray; new barrier works
    set_req(1'b1, 4'd5, 8'h77);
    tick();
    set_req(1'b0, 4'd0, 8'h00);
    tick();
    tick();
    chk_all("t6.wait", 0, 0, 0, 0, 0, 0, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_all("t6.reset", 0, 1, 0, 0, 0, 0, 0);
    set_wake(1'b1, 4'd5, 8'h77, 1'b0);
    tick();
    set_wake(1'b0, 4'd0, 8'h00, 1'b0);
    chk_all("t6.stray", 0, 1, 0, 0, 0, 1, 0);
    set_req(1'b1, 4'd5, 8'h78);
    tick();
    set_req(1'b0, 4'd0, 8'h00);
    chk_all("t6.pulse", 0, 0, 0, 0, 1, 0, 1);
    tick();
    set_wake(1'b1, 4'd5, 8'h78, 1'b0);
    tick();
    set_wake(1'b0, 4'd0, 8'h00, 1'b0);
    chk_all("t6.rsp", 1, 0, 0, 0, 0, 0, 1);
    core_rsp_ready_i = 1'b1;
    tick();
    core_rsp_ready_i = 1'b0;
    chk_all("t6.done", 0, 1, 0, 0, 0, 0, 0);

    // 7: match on the timeout cycle wins; wake during RESP is a stray
    set_req(1'b1, 4'd6, 8'h99);
    tick();
    set_req(1'b0, 4'd0, 8'h00);
    for (int i = 1; i <= 8; i++) tick();
    set_wake(1'b1, 4'd6, 8'h99, 1'b0);
    tick();
    set_wake(1'b0, 4'd0, 8'h00, 1'b0);
    chk_all("t7.rsp", 1, 0, 0, 0, 0, 0, 1);
    set_wake(1'b1, 4'd6, 8'h99, 1'b0);
    core_rsp_ready_i = 1'b1;
    tick();
    core_rsp_ready_i = 1'b0;
    set_wake(1'b0, 4'd0, 8'h00, 1'b0);
    chk_all("t7.resp_stray", 0, 1, 0, 0, 0, 1, 0);
    tick();
    chk_all("t7.end", 0, 1, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
